zbb_encoder: RTL and testbench

ZBB_ENCODER -- requirements
Module: zbb_encoder

---
 rtl/zbb_encoder_pkg.sv | 54 +++++
 rtl/zbb_encoder_fifo.sv | 55 +++++
 rtl/zbb_encoder.sv | 101 ++++++++++
 tb/tb_zbb_encoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbb_encoder_pkg.sv
// Shared constants for the Zbb instruction encoder: request op codes, RISC-V
// opcode/funct fields, write-FSM states and the combinational word builder.
package zbb_encoder_pkg;

    typedef enum logic [2:0] {
        OP_ANDN    = 3'd0,
        OP_ORN     = 3'd1,
        OP_XNOR    = 3'd2,
        OP_CLZ     = 3'd3,
        OP_CTZ     = 3'd4,
        OP_CPOP    = 3'd5,
        OP_MAX     = 3'd6,
        OP_ILLEGAL = 3'd7
    } zbb_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    localparam logic [6:0]  OPC_OP       = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0]  F7_NEG       = 7'b0100000;
    localparam logic [6:0]  F7_MINMAX    = 7'b0000101;
    localparam logic [2:0]  F3_ANDN      = 3'b111;
    localparam logic [2:0]  F3_ORN       = 3'b110;
    localparam logic [2:0]  F3_XNOR      = 3'b100;
    localparam logic [2:0]  F3_MAX       = 3'b110;
    localparam logic [2:0]  F3_UNARY     = 3'b001;
    localparam logic [11:0] IMM_CLZ      = 12'h600;
    localparam logic [11:0] IMM_CTZ      = 12'h601;
    localparam logic [11:0] IMM_CPOP     = 12'h602;

    // Unary ops carry their selector in imm[11:0], so rs2 never reaches the word.
    function automatic logic [31:0] zbb_encode(input logic [2:0] op,
                                               input logic [4:0] rd,
                                               input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        logic [31:0] word;
        word = '0;
        case (zbb_op_e'(op))
            OP_ANDN: word = {F7_NEG, rs2, rs1, F3_ANDN, rd, OPC_OP};
            OP_ORN:  word = {F7_NEG, rs2, rs1, F3_ORN, rd, OPC_OP};
            OP_XNOR: word = {F7_NEG, rs2, rs1, F3_XNOR, rd, OPC_OP};
            OP_MAX:  word = {F7_MINMAX, rs2, rs1, F3_MAX, rd, OPC_OP};
            OP_CLZ:  word = {IMM_CLZ, rs1, F3_UNARY, rd, OPC_OP_IMM};
            OP_CTZ:  word = {IMM_CTZ, rs1, F3_UNARY, rd, OPC_OP_IMM};
            OP_CPOP: word = {IMM_CPOP, rs1, F3_UNARY, rd, OPC_OP_IMM};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/zbb_encoder_fifo.sv
// Request FIFO holding encoded 32-bit instruction words; head is read
// combinationally so the writer can present it without an extra cycle.
module zbb_enc_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    output logic [31:0]            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (occ == (PTR_W+1)'(DEPTH));
    assign empty = (occ == '0);
    assign count = occ;

endmodule

// File: rtl/zbb_encoder.sv
// Encodes Zbb operation requests into RISC-V words, queues them and writes
// them to consecutive instruction-memory addresses under a mem_ack handshake.
module zbb_encoder
    import zbb_encoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err_illegal,
    output logic              busy,
    output logic [15:0]       words_written
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wr_state_e         state;
    wr_state_e         next_state;
    logic [ADDR_W-1:0] addr_ptr;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic [31:0]       enc_word;
    logic [31:0]       fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign accept   = req_valid && req_ready;
    assign legal    = (req_op != OP_ILLEGAL);
    assign push     = accept && legal;
    assign pop      = (state == ST_WRITE) && mem_ack;
    assign enc_word = zbb_encode(req_op, req_rd, req_rs1, req_rs2);

    zbb_enc_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(enc_word),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Looks at the occupancy after this edge so WRITE starts the cycle after a push.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (push || !fifo_empty) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (pop && (fifo_count == CNT_W'(1)) && !push) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr_ptr      <= '0;
            words_written <= '0;
            err_illegal   <= 1'b0;
        end else begin
            state       <= next_state;
            err_illegal <= accept && !legal;
            if (pop) begin
                addr_ptr      <= addr_ptr + ADDR_W'(1);
                words_written <= words_written + 16'd1;
            end else if (cfg_load && (state == ST_IDLE) && fifo_empty) begin
                addr_ptr <= cfg_addr;
            end
        end
    end

    assign mem_we    = (state == ST_WRITE);
    assign mem_addr  = addr_ptr;
    assign mem_wdata = mem_we ? fifo_head : 32'd0;
    assign busy      = mem_we || !fifo_empty;
    assign req_ready = !fifo_full;

endmodule

// File: tb/tb_zbb_encoder.sv
// Scoreboard bench for zbb_encoder: stimulus pushes expected writes, a negedge
// monitor pops and compares them whenever the DUT completes a handshake.
module tb_zbb_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } sb_entry_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic              cfg_load;
    logic [ADDR_W-1:0] cfg_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              err_illegal;
    logic              busy;
    logic [15:0]       words_written;

    sb_entry_t         sb_q[$];
    bit                err_cycles[int];
    int                checks;
    int                errors;
    int                pos_count;
    int                exp_words;
    logic [ADDR_W-1:0] model_addr;
    int                ack_mode;
    bit                prev_hold;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;

    zbb_encoder #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .cfg_load     (cfg_load),
        .cfg_addr     (cfg_addr),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .err_illegal  (err_illegal),
        .busy         (busy),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pos_count <= pos_count + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from field values with plain arithmetic.
    function automatic logic [31:0] model_word(input int op, input int rd, input int rs1, input int rs2);
        longint w;
        int f7;
        int f3;
        int imm;
        w = 0;
        f7 = 0;
        f3 = 0;
        imm = 0;
        case (op)
            0: begin f7 = 32; f3 = 7; end
            1: begin f7 = 32; f3 = 6; end
            2: begin f7 = 32; f3 = 4; end
            6: begin f7 = 5;  f3 = 6; end
            3: imm = 1536;
            4: imm = 1537;
            5: imm = 1538;
            default: ;
        endcase
        if (op == 0 || op == 1 || op == 2 || op == 6)
            w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51;
        else if (op >= 3 && op <= 5)
            w = imm * 1048576 + rs1 * 32768 + 1 * 4096 + rd * 128 + 19;
        return w[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] expect_word);
        sb_entry_t e;
        bit accepted;
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        accepted  = 1'b0;
        for (int n = 0; n < 300 && !accepted; n++) begin
            @(negedge clk);
            if (req_ready) accepted = 1'b1;
        end
        if (accepted) begin
            if (op == 7) begin
                err_cycles[pos_count + 1] = 1'b1;
            end else begin
                e.addr = model_addr;
                e.data = expect_word;
                sb_q.push_back(e);
                model_addr = model_addr + 8'd1;
            end
        end
        check_output("send_accept", 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input int op, input int rd, input int rs1, input int rs2);
        send(op, rd, rs1, rs2, model_word(op, rd, rs1, rs2));
    endtask

    task automatic cfg_write(input logic [ADDR_W-1:0] addr, input bit applied);
        cfg_load = 1'b1;
        cfg_addr = addr;
        step();
        cfg_load = 1'b0;
        if (applied) model_addr = addr;
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && sb_q.size() != 0; n++) @(posedge clk);
        check_output("drain_empty", 32'(sb_q.size()), 32'd0);
        step();
        step();
        @(negedge clk);
        check_output("drain_busy", 32'(busy), 32'd0);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb_q.delete();
        err_cycles.delete();
        exp_words  = 0;
        model_addr = '0;
    endtask

    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       mem_ack = 1'b0;
                1:       mem_ack = 1'b1;
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: counters and pulses every cycle, scoreboard pop on each accepted write.
    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            check_output("words_written", 32'(words_written), 32'(exp_words[15:0]));
            check_output("err_illegal", 32'(err_illegal), 32'(err_cycles.exists(pos_count)));
            if (sb_q.size() == 0) check_output("idle_we", 32'(mem_we), 32'd0);
            if (prev_hold && mem_we) begin
                check_output("hold_addr", 32'(mem_addr), 32'(prev_addr));
                check_output("hold_data", mem_wdata, prev_data);
            end
            if (mem_we && mem_ack && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_output("write_addr", 32'(mem_addr), 32'(e.addr));
                check_output("write_data", mem_wdata, e.data);
                exp_words++;
            end
            prev_hold = mem_we && !mem_ack;
            prev_addr = mem_addr;
            prev_data = mem_wdata;
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        pos_count  = 0;
        exp_words  = 0;
        model_addr = '0;
        ack_mode   = 0;
        prev_hold  = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_rd     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        cfg_load   = 1'b0;
        cfg_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check_output("rst_we", 32'(mem_we), 32'd0);
        check_output("rst_wdata", mem_wdata, 32'd0);
        check_output("rst_addr", 32'(mem_addr), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_ready", 32'(req_ready), 32'd1);
        step();

        ack_mode = 1;
        send(0, 3, 1, 2, 32'h4020F1B3);
        drain();
        send(3, 5, 6, 0, 32'h60031293);
        send(5, 5, 6, 31, 32'h60231293);
        drain();

        ack_mode = 0;
        step();
        apply_stimulus(2, 1, 2, 3);
        @(negedge clk);
        check_output("latency_we", 32'(mem_we), 32'd1);
        ack_mode = 1;
        drain();

        cfg_write(8'hFF, 1'b1);
        apply_stimulus(1, 7, 8, 9);
        apply_stimulus(6, 10, 11, 12);
        drain();

        ack_mode = 0;
        step();
        apply_stimulus(4, 2, 4, 6);
        cfg_write(8'h40, 1'b0);
        ack_mode = 1;
        drain();

        send(7, 1, 1, 1, 32'd0);
        repeat (3) step();

        ack_mode = 0;
        step();
        for (int i = 0; i < 4; i++) apply_stimulus(i, i + 1, i + 2, i + 3);
        @(negedge clk);
        check_output("full_ready", 32'(req_ready), 32'd0);
        step();
        fork
            apply_stimulus(6, 31, 30, 29);
            begin
                repeat (5) @(posedge clk);
                ack_mode = 1;
            end
        join
        drain();

        for (int i = 0; i < 6; i++) apply_stimulus(i, 31 - i, i, 2 * i);
        drain();

        ack_mode = 2;
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) step();
        end
        ack_mode = 1;
        drain();

        ack_mode = 0;
        step();
        for (int i = 0; i < 3; i++) apply_stimulus(i, 4, 5, 6);
        do_reset();
        @(negedge clk);
        check_output("rst2_we", 32'(mem_we), 32'd0);
        check_output("rst2_busy", 32'(busy), 32'd0);
        check_output("rst2_ready", 32'(req_ready), 32'd1);
        check_output("rst2_addr", 32'(mem_addr), 32'd0);
        step();
        ack_mode = 1;
        apply_stimulus(5, 9, 9, 9);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
